spi_ram_arbiter: RTL and testbench
==================================

# spi_ram_arbiter

Owns the single-port RAM behind the SPI slave and shares it between two requesters: the SPI command stream (10-bit words from the SPI slave) and a local host port. Decodes SPI opcodes into address-pointer updates and RAM reads and writes, and arbitrates RAM cycles round-robin. Returns read data to the SPI slave (`spi_tx_data`/`spi_tx_valid`) or to the host (`host_rdata`/`host_rvalid`). Sits between `SPI_Slave` and the RAM, replacing direct slave-to-RAM wiring.

## Interface
- `MEM_DEPTH`, 256, RAM words.
- `ADDR_SIZE`, 8, RAM address width. Address fields are taken from the low `ADDR_SIZE` bits of the payload byte.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_rx_data` in 10: `[9:8]` opcode, `[7:0]` payload.
- `spi_rx_valid` in 1: level from slave; may stay high for many cycles per word.
- `spi_tx_data` out 8: read data to slave.
- `spi_tx_valid` out 1: read data valid, held (see Operation).
- `spi_overrun` out 1: 1-cycle pulse when an SPI data command is dropped.
- `host_req` in 1: host access request, held until `host_gnt`.
- `host_we` in 1: 1 = write, 0 = read; held with `host_req`.
- `host_addr` in `ADDR_SIZE`: host address; held with `host_req`.
- `host_wdata` in 8: host write data; held with `host_req`.
- `host_gnt` out 1: 1-cycle pulse in the ACCESS cycle for the host.
- `host_rdata` out 8: host read data.
- `host_rvalid` out 1: 1-cycle pulse, `host_rdata` valid.
- `ram_en` out 1: RAM cycle enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out `ADDR_SIZE`: RAM address.
- `ram_wdata` out 8: RAM write data.
- `ram_rdata` in 8: RAM read data, valid the cycle after `ram_en && !ram_we`.

## Operation
- **SPI word detect:** register `spi_rx_valid`. A new word is accepted only on a rising edge (`spi_rx_valid && !rx_valid_q`). Holding the level high never re-triggers.
- **Opcode 00:** `wr_addr <= payload`. No RAM cycle.
- **Opcode 10:** `rd_addr <= payload`. No RAM cycle.
- **Address commands** are always accepted, regardless of pending or RAM state.
- **Opcode 01:** enqueue an SPI write of `{wr_addr, payload}`. The address is captured at enqueue time.
- **Opcode 11:** enqueue an SPI read of `rd_addr`, captured at enqueue time. The payload is ignored.
- **Pending slot:** the SPI side has a single slot. If a data command arrives while the slot is full, the command is dropped, `spi_overrun` pulses, and the slot is unchanged.
- **FSM states:** IDLE, ACCESS, CAPTURE.
- **IDLE:** if any requester is pending, latch the winner into `owner` and go to ACCESS; otherwise stay in IDLE.
- **ACCESS:**
  - Drive `ram_en = 1`, with `ram_we`, `ram_addr` and `ram_wdata` taken from `owner`.
  - If the owner is the host, pulse `host_gnt`.
  - If the owner is SPI, clear the slot.
  - After a write, go to IDLE; after a read, go to CAPTURE.
- **CAPTURE:** register `ram_rdata` into `spi_tx_data` or `host_rdata` per `owner`, then go to IDLE.
- **Arbitration:** round-robin over {SPI, host}.
  - When both are pending in IDLE, grant the requester not served last.
  - `last` resets to host, so SPI wins the first tie.
  - A lone requester always wins.
- **`spi_tx_valid`:** set at CAPTURE for an SPI read. Cleared on the falling edge of `spi_rx_valid` (end of slave frame) or on the next SPI data enqueue, whichever comes first. Clear has priority over set in the same cycle.
- **Outputs when not in ACCESS:** `ram_en`, `ram_we`, `ram_addr` and `ram_wdata` are all 0.
- **Reset:**
  - Outputs all 0; FSM in IDLE.
  - Slot empty; `wr_addr` and `rd_addr` = 0; `last` = host; `rx_valid_q` = 0.
  - Reset mid-access aborts with no further RAM cycle and no `rvalid`.

## Timing
- Let cycle k be the first cycle `spi_rx_valid` is high.
- **Uncontended SPI read:**
  - Slot full from k+1.
  - ACCESS in cycle k+2.
  - CAPTURE in cycle k+3.
  - `spi_tx_valid` and `spi_tx_data` visible from k+4.
- **Uncontended SPI write:** RAM write in cycle k+2.
- **Host request:**
  - `host_req` sampled in IDLE at cycle h; ACCESS and `host_gnt` at h+1.
  - Read: `host_rvalid` at h+3. Write: done at h+1.
  - The host may change inputs from h+2.
- **Contention:** worst-case extra latency for either side is one full foreign read (3 cycles).
- **Throughput:** back-to-back RAM cycles are not possible; at least one IDLE cycle separates accesses.

## Structure
- **Package `spi_ram_pkg`:**
  - Opcode constants `CMD_WR_ADDR` = 2'b00, `CMD_WR_DATA` = 2'b01, `CMD_RD_ADDR` = 2'b10, `CMD_RD_DATA` = 2'b11.
  - FSM state encoding.
  - Owner encoding `OWN_SPI` / `OWN_HOST`.
- **Sub-module `ram_arb_rr2`:** two-request round-robin arbiter. Inputs `req[1:0]` and `advance`; output one-hot `gnt[1:0]`; holds the `last` register.
- The top level holds opcode decode, the pending slot, address pointers, FSM and output registers.

## Test plan
- **SPI write then read:**
  - Stimulus: rising-edge words 0x005, 0x1A7, 0x205, 0x300.
  - RAM[5] = 0xA7; `spi_tx_data` = 0xA7.
  - `spi_tx_valid` rises at k+4 after 0x300 and holds until `spi_rx_valid` falls.
- **Level hold:** `spi_rx_valid` held high 20 cycles with 0x1A7 → exactly one RAM write.
- **Tie:** host read of addr 3 and SPI write to addr 3 pending in the same IDLE cycle after reset.
  - SPI is served first, then the host.
  - `host_rdata` = the SPI-written value; `host_rvalid` 1 cycle.
- **Overrun:** two SPI data words while the host holds the RAM.
  - `spi_overrun` pulses once; only the first word reaches the RAM.
- **Reset in CAPTURE:** assert `rst_n` low during CAPTURE.
  - All outputs 0 immediately.
  - No `host_rvalid`; `spi_tx_valid` 0 after release.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared constants and encodings for the SPI/host RAM arbiter.
package spi_ram_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int ADDR_SIZE = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACCESS  = 2'b01,
    ST_CAPTURE = 2'b10
  } state_t;

  typedef enum logic {
    OWN_SPI  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  // Opcodes with bit 0 set touch the RAM; the others only move a pointer.
  function automatic logic is_data_cmd(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Bundle of the SPI word stream, host port and RAM port around the arbiter.
interface spi_ram_arbiter_if;
  import spi_ram_pkg::*;

  logic [9:0]           spi_rx_data;
  logic                 spi_rx_valid;
  logic [7:0]           spi_tx_data;
  logic                 spi_tx_valid;
  logic                 spi_overrun;
  logic                 host_req;
  logic                 host_we;
  logic [ADDR_SIZE-1:0] host_addr;
  logic [7:0]           host_wdata;
  logic                 host_gnt;
  logic [7:0]           host_rdata;
  logic                 host_rvalid;
  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [7:0]           ram_wdata;
  logic [7:0]           ram_rdata;

  modport slave (
    input  spi_rx_data, spi_rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
    output spi_tx_data, spi_tx_valid, spi_overrun, host_gnt, host_rdata, host_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output spi_rx_data, spi_rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
    input  spi_tx_data, spi_tx_valid, spi_overrun, host_gnt, host_rdata, host_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin arbiter; bit 0 is SPI, bit 1 is host.
module ram_arb_rr2
  import spi_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  owner_t     last_r;
  logic [1:0] gnt_s;

  // On a tie, grant whoever was not served last.
  always_comb begin
    gnt_s = 2'b00;
    if (req == 2'b11) begin
      if (last_r == OWN_HOST) begin
        gnt_s = 2'b01;
      end else begin
        gnt_s = 2'b10;
      end
    end else begin
      gnt_s = req;
    end
  end

  // Remember the requester served by the current grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= OWN_HOST;
    end else if (advance && (gnt_s != 2'b00)) begin
      last_r <= gnt_s[1] ? OWN_HOST : OWN_SPI;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Decodes SPI opcodes and shares one single-port RAM between SPI and host.
module spi_ram_arbiter
  import spi_ram_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  spi_ram_arbiter_if.slave bus
);

  logic [1:0]           opcode_s;
  logic [7:0]           payload_s;
  logic                 rx_valid_q_r;
  logic                 rise_s;
  logic                 fall_s;
  logic                 data_cmd_s;
  logic                 enqueue_s;
  logic                 overrun_s;

  logic [ADDR_SIZE-1:0] wr_addr_r;
  logic [ADDR_SIZE-1:0] rd_addr_r;
  logic                 slot_full_r;
  logic                 slot_we_r;
  logic [ADDR_SIZE-1:0] slot_addr_r;
  logic [7:0]           slot_wdata_r;

  state_t               state_r;
  owner_t               owner_r;
  logic [1:0]           req_s;
  logic [1:0]           gnt_s;
  logic                 advance_s;

  logic                 ram_en_r;
  logic                 ram_we_r;
  logic [ADDR_SIZE-1:0] ram_addr_r;
  logic [7:0]           ram_wdata_r;
  logic                 host_gnt_r;
  logic [7:0]           host_rdata_r;
  logic                 host_rvalid_r;
  logic [7:0]           spi_tx_data_r;
  logic                 spi_tx_valid_r;
  logic                 spi_overrun_r;

  assign opcode_s   = bus.spi_rx_data[9:8];
  assign payload_s  = bus.spi_rx_data[7:0];
  assign rise_s     = bus.spi_rx_valid && !rx_valid_q_r;
  assign fall_s     = !bus.spi_rx_valid && rx_valid_q_r;
  assign data_cmd_s = rise_s && is_data_cmd(opcode_s);
  assign enqueue_s  = data_cmd_s && !slot_full_r;
  assign overrun_s  = data_cmd_s && slot_full_r;

  assign req_s      = {bus.host_req, slot_full_r};
  assign advance_s  = (state_r == ST_IDLE) && (req_s != 2'b00);

  ram_arb_rr2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_s),
    .advance (advance_s),
    .gnt     (gnt_s)
  );

  // SPI word decode: pointers, the single pending slot and overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q_r  <= 1'b0;
      wr_addr_r     <= '0;
      rd_addr_r     <= '0;
      slot_full_r   <= 1'b0;
      slot_we_r     <= 1'b0;
      slot_addr_r   <= '0;
      slot_wdata_r  <= 8'h00;
      spi_overrun_r <= 1'b0;
    end else begin
      rx_valid_q_r  <= bus.spi_rx_valid;
      spi_overrun_r <= overrun_s;
      if (rise_s && (opcode_s == CMD_WR_ADDR)) begin
        wr_addr_r <= payload_s[ADDR_SIZE-1:0];
      end else if (rise_s && (opcode_s == CMD_RD_ADDR)) begin
        rd_addr_r <= payload_s[ADDR_SIZE-1:0];
      end
      // Enqueue and the ACCESS-time clear are exclusive: enqueue needs an empty slot.
      if (enqueue_s) begin
        slot_full_r  <= 1'b1;
        slot_we_r    <= (opcode_s == CMD_WR_DATA);
        slot_addr_r  <= (opcode_s == CMD_WR_DATA) ? wr_addr_r : rd_addr_r;
        slot_wdata_r <= payload_s;
      end else if ((state_r == ST_ACCESS) && (owner_r == OWN_SPI)) begin
        slot_full_r <= 1'b0;
      end
    end
  end

  // RAM cycle FSM with registered RAM, grant and read-return outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      owner_r        <= OWN_SPI;
      ram_en_r       <= 1'b0;
      ram_we_r       <= 1'b0;
      ram_addr_r     <= '0;
      ram_wdata_r    <= 8'h00;
      host_gnt_r     <= 1'b0;
      host_rdata_r   <= 8'h00;
      host_rvalid_r  <= 1'b0;
      spi_tx_data_r  <= 8'h00;
      spi_tx_valid_r <= 1'b0;
    end else begin
      ram_en_r      <= 1'b0;
      ram_we_r      <= 1'b0;
      ram_addr_r    <= '0;
      ram_wdata_r   <= 8'h00;
      host_gnt_r    <= 1'b0;
      host_rvalid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_s != 2'b00) begin
            state_r  <= ST_ACCESS;
            ram_en_r <= 1'b1;
            if (gnt_s[1]) begin
              owner_r     <= OWN_HOST;
              host_gnt_r  <= 1'b1;
              ram_we_r    <= bus.host_we;
              ram_addr_r  <= bus.host_addr;
              ram_wdata_r <= bus.host_wdata;
            end else begin
              owner_r     <= OWN_SPI;
              ram_we_r    <= slot_we_r;
              ram_addr_r  <= slot_addr_r;
              ram_wdata_r <= slot_wdata_r;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_r <= ram_we_r ? ST_IDLE : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_r <= ST_IDLE;
          if (owner_r == OWN_HOST) begin
            host_rdata_r  <= bus.ram_rdata;
            host_rvalid_r <= 1'b1;
          end else begin
            spi_tx_data_r <= bus.ram_rdata;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      // End of frame or a new data command withdraws the previous read result.
      if (fall_s || enqueue_s) begin
        spi_tx_valid_r <= 1'b0;
      end else if ((state_r == ST_CAPTURE) && (owner_r == OWN_SPI)) begin
        spi_tx_valid_r <= 1'b1;
      end
    end
  end

  assign bus.ram_en       = ram_en_r;
  assign bus.ram_we       = ram_we_r;
  assign bus.ram_addr     = ram_addr_r;
  assign bus.ram_wdata    = ram_wdata_r;
  assign bus.host_gnt     = host_gnt_r;
  assign bus.host_rdata   = host_rdata_r;
  assign bus.host_rvalid  = host_rvalid_r;
  assign bus.spi_tx_data  = spi_tx_data_r;
  assign bus.spi_tx_valid = spi_tx_valid_r;
  assign bus.spi_overrun  = spi_overrun_r;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench: SPI vector table, directed corner sequences, randomized traffic vs a memory model.
module tb_spi_ram_arbiter;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_ram_arbiter_if bus();

  spi_ram_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  int wr_cnt = 0;
  int en_cnt = 0;
  int ovr_cnt = 0;
  int rv_cnt = 0;

  // Behavioural RAM with one-cycle read latency plus event counters.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata <= mem[bus.ram_addr];
    end
    if (bus.ram_en) en_cnt <= en_cnt + 1;
    if (bus.ram_en && bus.ram_we) wr_cnt <= wr_cnt + 1;
    if (bus.spi_overrun) ovr_cnt <= ovr_cnt + 1;
    if (bus.host_rvalid) rv_cnt <= rv_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0] word;
    logic       exp_en;
    logic       exp_we;
    logic [7:0] exp_addr;
    logic [7:0] exp_wdata;
    logic       exp_txv;
    logic [7:0] exp_txd;
  } vec_t;
  vec_t vecs [9];

  logic [7:0] shadow [256];
  logic       known [256];
  logic [7:0] wlist [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {26'd0, bus.spi_tx_data, bus.spi_tx_valid, bus.spi_overrun, bus.host_gnt,
            bus.host_rdata, bus.host_rvalid, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.spi_rx_valid = 1'b0;
    bus.host_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic spi_cmd(input logic [9:0] w);
    bus.spi_rx_data = w;
    bus.spi_rx_valid = 1'b1;
    tick();
    bus.spi_rx_valid = 1'b0;
    tick();
  endtask

  initial begin
    int c_wr, c_en, c_ovr, c_rv, kind, idx;
    logic [7:0] a, d, wp, rp;

    bus.spi_rx_data = 10'h000;
    bus.spi_rx_valid = 1'b0;
    bus.host_req = 1'b0;
    bus.host_we = 1'b0;
    bus.host_addr = 8'h00;
    bus.host_wdata = 8'h00;

    vecs[0] = '{10'h005, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[1] = '{10'h1A7, 1'b1, 1'b1, 8'h05, 8'hA7, 1'b0, 8'h00};
    vecs[2] = '{10'h205, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[3] = '{10'h300, 1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'hA7};
    vecs[4] = '{10'h0FF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[5] = '{10'h13C, 1'b1, 1'b1, 8'hFF, 8'h3C, 1'b0, 8'h00};
    vecs[6] = '{10'h2FF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[7] = '{10'h311, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h3C};
    vecs[8] = '{10'h3EE, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h3C};

    tick();
    chk("reset_outputs", all_outs(), 64'd0);
    do_reset();
    chk("post_reset_outputs", all_outs(), 64'd0);

    // Table: word at cycle k, RAM cycle at k+2, read data at k+4, held until frame end.
    for (int i = 0; i < 9; i++) begin
      bus.spi_rx_data = vecs[i].word;
      bus.spi_rx_valid = 1'b1;
      tick();
      tick();
      chk($sformatf("vec%0d_ram_en", i), 64'(bus.ram_en), 64'(vecs[i].exp_en));
      if (vecs[i].exp_en) begin
        chk($sformatf("vec%0d_ram_we", i), 64'(bus.ram_we), 64'(vecs[i].exp_we));
        chk($sformatf("vec%0d_ram_addr", i), 64'(bus.ram_addr), 64'(vecs[i].exp_addr));
      end
      if (vecs[i].exp_we) chk($sformatf("vec%0d_ram_wdata", i), 64'(bus.ram_wdata), 64'(vecs[i].exp_wdata));
      tick();
      tick();
      chk($sformatf("vec%0d_tx_valid", i), 64'(bus.spi_tx_valid), 64'(vecs[i].exp_txv));
      if (vecs[i].exp_txv) begin
        chk($sformatf("vec%0d_tx_data", i), 64'(bus.spi_tx_data), 64'(vecs[i].exp_txd));
        tick();
        chk($sformatf("vec%0d_tx_hold", i), 64'(bus.spi_tx_valid), 64'd1);
      end
      bus.spi_rx_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_tx_cleared", i), 64'(bus.spi_tx_valid), 64'd0);
      tick();
    end
    chk("ram5_content", 64'(mem[5]), 64'hA7);

    // Level held high for 20 cycles must produce a single write.
    c_wr = wr_cnt;
    bus.spi_rx_data = 10'h1A7;
    bus.spi_rx_valid = 1'b1;
    repeat (20) tick();
    bus.spi_rx_valid = 1'b0;
    repeat (3) tick();
    chk("level_hold_writes", 64'(wr_cnt - c_wr), 64'd1);

    // Overrun: two data words while the host read owns the RAM.
    spi_cmd(10'h007);
    c_wr = wr_cnt;
    c_ovr = ovr_cnt;
    bus.host_req = 1'b1;
    bus.host_we = 1'b0;
    bus.host_addr = 8'h05;
    tick();
    chk("ovr_host_gnt", 64'(bus.host_gnt), 64'd1);
    bus.host_req = 1'b0;
    bus.spi_rx_data = 10'h111;
    bus.spi_rx_valid = 1'b1;
    tick();
    bus.spi_rx_valid = 1'b0;
    tick();
    chk("ovr_host_rvalid", 64'(bus.host_rvalid), 64'd1);
    chk("ovr_host_rdata", 64'(bus.host_rdata), 64'hA7);
    bus.spi_rx_data = 10'h122;
    bus.spi_rx_valid = 1'b1;
    tick();
    chk("ovr_spi_write", 64'({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}), 64'({2'b11, 8'h07, 8'h11}));
    chk("ovr_pulse", 64'(bus.spi_overrun), 64'd1);
    tick();
    chk("ovr_pulse_end", 64'(bus.spi_overrun), 64'd0);
    bus.spi_rx_valid = 1'b0;
    repeat (4) tick();
    chk("ovr_pulse_count", 64'(ovr_cnt - c_ovr), 64'd1);
    chk("ovr_write_count", 64'(wr_cnt - c_wr), 64'd1);
    chk("ovr_ram7", 64'(mem[7]), 64'h11);

    // Tie after reset: SPI wins first, host reads the value SPI wrote.
    do_reset();
    spi_cmd(10'h003);
    bus.spi_rx_data = 10'h15E;
    bus.spi_rx_valid = 1'b1;
    tick();
    bus.host_req = 1'b1;
    bus.host_we = 1'b0;
    bus.host_addr = 8'h03;
    tick();
    chk("tie_spi_first", 64'({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}), 64'({2'b11, 8'h03, 8'h5E}));
    chk("tie_no_gnt_yet", 64'(bus.host_gnt), 64'd0);
    bus.spi_rx_valid = 1'b0;
    tick();
    chk("tie_idle_gap", 64'(bus.ram_en), 64'd0);
    tick();
    chk("tie_host_gnt", 64'({bus.host_gnt, bus.ram_en, bus.ram_we, bus.ram_addr}), 64'({3'b110, 8'h03}));
    bus.host_req = 1'b0;
    tick();
    tick();
    chk("tie_rvalid", 64'(bus.host_rvalid), 64'd1);
    chk("tie_rdata", 64'(bus.host_rdata), 64'h5E);
    tick();
    chk("tie_rvalid_pulse", 64'(bus.host_rvalid), 64'd0);

    // Reset during an SPI read CAPTURE.
    spi_cmd(10'h203);
    bus.spi_rx_data = 10'h300;
    bus.spi_rx_valid = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    bus.spi_rx_valid = 1'b0;
    #1;
    chk("rst_spi_cap_outputs", all_outs(), 64'd0);
    tick();
    c_en = en_cnt;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_spi_cap_txv", 64'(bus.spi_tx_valid), 64'd0);
    chk("rst_spi_cap_no_ram", 64'(en_cnt - c_en), 64'd0);

    // Reset during a host read CAPTURE.
    bus.host_req = 1'b1;
    bus.host_we = 1'b0;
    bus.host_addr = 8'h03;
    tick();
    bus.host_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_host_cap_outputs", all_outs(), 64'd0);
    c_rv = rv_cnt;
    c_en = en_cnt;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_host_cap_no_rvalid", 64'(rv_cnt - c_rv), 64'd0);
    chk("rst_host_cap_no_ram", 64'(en_cnt - c_en), 64'd0);

    // Randomized serialized traffic against a memory/pointer model.
    do_reset();
    wp = 8'h00;
    rp = 8'h00;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 3));
      if ((kind == 1 || kind == 3) && wlist.size() == 0) kind = kind - 1;
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      if (kind == 1 || kind == 3) begin
        idx = int'($urandom_range(0, wlist.size() - 1));
        a = wlist[idx];
      end
      case (kind)
        0: begin
          if (a != wp || $urandom_range(0, 1) == 1) spi_cmd({CMD_WR_ADDR, a});
          wp = a;
          bus.spi_rx_data = {CMD_WR_DATA, d};
          bus.spi_rx_valid = 1'b1;
          tick();
          tick();
          chk("rnd_spi_wr", 64'({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}), 64'({2'b11, wp, d}));
          bus.spi_rx_valid = 1'b0;
          tick();
          tick();
          shadow[wp] = d;
          if (!known[wp]) begin
            known[wp] = 1'b1;
            wlist.push_back(wp);
          end
        end
        1: begin
          if (a != rp || $urandom_range(0, 1) == 1) spi_cmd({CMD_RD_ADDR, a});
          rp = a;
          bus.spi_rx_data = {CMD_RD_DATA, d};
          bus.spi_rx_valid = 1'b1;
          repeat (4) tick();
          chk("rnd_spi_rd_valid", 64'(bus.spi_tx_valid), 64'd1);
          chk("rnd_spi_rd_data", 64'(bus.spi_tx_data), 64'(shadow[rp]));
          bus.spi_rx_valid = 1'b0;
          tick();
          chk("rnd_spi_rd_clear", 64'(bus.spi_tx_valid), 64'd0);
        end
        2: begin
          bus.host_req = 1'b1;
          bus.host_we = 1'b1;
          bus.host_addr = a;
          bus.host_wdata = d;
          tick();
          chk("rnd_host_wr", 64'({bus.host_gnt, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}),
              64'({3'b111, a, d}));
          bus.host_req = 1'b0;
          tick();
          tick();
          shadow[a] = d;
          if (!known[a]) begin
            known[a] = 1'b1;
            wlist.push_back(a);
          end
        end
        default: begin
          bus.host_req = 1'b1;
          bus.host_we = 1'b0;
          bus.host_addr = a;
          tick();
          chk("rnd_host_rd_gnt", 64'({bus.host_gnt, bus.ram_en, bus.ram_we, bus.ram_addr}), 64'({3'b110, a}));
          bus.host_req = 1'b0;
          tick();
          tick();
          chk("rnd_host_rvalid", 64'(bus.host_rvalid), 64'd1);
          chk("rnd_host_rdata", 64'(bus.host_rdata), 64'(shadow[a]));
          tick();
          chk("rnd_host_rvalid_pulse", 64'(bus.host_rvalid), 64'd0);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
